// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the lane FIFO family.
package fifo_pkg;

    localparam int BW_DEF    = 8;
    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 16;
    localparam int FWFT_DEF  = 0;
    localparam int AE_DEF    = 2;

    // Occupancy needs one extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_lanes_if.sv
// Write/read handshake, data and status bundle for fifo_lanes.
interface fifo_lanes_if
    import fifo_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int width = WIDTH_DEF,
    parameter int depth = DEPTH_DEF
) ();

    logic [width*bw-1:0]        in;
    logic                       wr;
    logic                       rd;
    logic                       clr_err;
    logic [width*bw-1:0]        out;
    logic                       o_full;
    logic                       o_empty;
    logic                       o_ready;
    logic                       o_afull;
    logic                       o_aempty;
    logic [cnt_w(depth)-1:0]    o_count;
    logic                       o_ovf;
    logic                       o_udf;

    modport master (
        output in, wr, rd, clr_err,
        input  out, o_full, o_empty, o_ready, o_afull, o_aempty, o_count, o_ovf, o_udf
    );

    modport slave (
        input  in, wr, rd, clr_err,
        output out, o_full, o_empty, o_ready, o_afull, o_aempty, o_count, o_ovf, o_udf
    );

endinterface

// File: rtl/fifo_mem.sv
// Entry storage: synchronous write, asynchronous read; contents are never reset.
module fifo_mem #(
    parameter int dw    = 32,
    parameter int depth = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(depth)-1:0] waddr,
    input  logic [dw-1:0]            wdat,
    input  logic [$clog2(depth)-1:0] raddr,
    output logic [dw-1:0]            rdat
);

    logic [dw-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdat;
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/fifo_lanes.sv
// Multi-lane synchronous FIFO: 1-cycle registered read (fwft=0) or 0-cycle fall-through (fwft=1).
// Writes are refused while full and reads while empty; refusals raise sticky ovf/udf flags.
module fifo_lanes
    import fifo_pkg::*;
#(
    parameter int bw       = BW_DEF,
    parameter int width    = WIDTH_DEF,
    parameter int depth    = DEPTH_DEF,
    parameter int fwft     = FWFT_DEF,
    parameter int af_level = depth - 2,
    parameter int ae_level = AE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fifo_lanes_if.slave  bus
);

    localparam int aw = $clog2(depth);
    localparam int cw = cnt_w(depth);
    localparam int dw = width * bw;

    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [cw-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;
    logic          ovf;
    logic          udf;
    logic [dw-1:0] head;

    assign full  = (count == cw'(depth));
    assign empty = (count == '0);

    // Acceptance looks only at pre-edge flags, so a read never frees room for a same-cycle write.
    assign wr_ok = bus.wr & ~full;
    assign rd_ok = bus.rd & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;

            if (wr_ok && !rd_ok)      count <= count + 1'b1;
            else if (rd_ok && !wr_ok) count <= count - 1'b1;

            // A new error event outranks a same-cycle clear.
            if (bus.wr && full)    ovf <= 1'b1;
            else if (bus.clr_err)  ovf <= 1'b0;

            if (bus.rd && empty)   udf <= 1'b1;
            else if (bus.clr_err)  udf <= 1'b0;
        end
    end

    fifo_mem #(
        .dw    (dw),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdat  (bus.in),
        .raddr (rd_ptr),
        .rdat  (head)
    );

    generate
        if (fwft != 0) begin : g_fwft
            assign bus.out = empty ? '0 : head;
        end else begin : g_reg
            logic [dw-1:0] out_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)     out_q <= '0;
                else if (rd_ok) out_q <= head;
            end

            assign bus.out = out_q;
        end
    endgenerate

    assign bus.o_full   = full;
    assign bus.o_empty  = empty;
    assign bus.o_ready  = ~full;
    assign bus.o_afull  = (count >= cw'(af_level));
    assign bus.o_aempty = (count <= cw'(ae_level));
    assign bus.o_count  = count;
    assign bus.o_ovf    = ovf;
    assign bus.o_udf    = udf;

endmodule

// File: doc/fifo_lanes.md
FIFO_LANES -- requirements
Module: fifo_lanes

Interface
REQ-001 Parameter bw, default 8, bits per lane.
REQ-002 Parameter width, default 4, lanes per entry; data bus is width*bw bits.
REQ-003 Parameter depth, default 16, entries; power of two, at least 4.
REQ-004 Parameter fwft, default 0; 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
REQ-005 Parameter af_level, default depth-2, almost-full threshold.
REQ-006 Parameter ae_level, default 2, almost-empty threshold.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-009 in  input  width*bw  write data, lane k at bits [k*bw +: bw].
REQ-010 wr  input  1  write request.
REQ-011 rd  input  1  read request.
REQ-012 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-013 out  output  width*bw  read data.
REQ-014 o_full / o_empty / o_ready  output  1 each  full, empty, and !full.
REQ-015 o_afull / o_aempty  output  1 each  almost-full, almost-empty.
REQ-016 o_count  output  $clog2(depth)+1  current occupancy.
REQ-017 o_ovf / o_udf  output  1 each  sticky overflow and underflow flags.

Function
REQ-018 A write is accepted when wr=1 and o_full=0; in is stored at wr_ptr and wr_ptr advances.
REQ-019 A read is accepted when rd=1 and o_empty=0; rd_ptr advances.
REQ-020 Acceptance uses pre-edge flags: when full, a write is rejected even if a read is accepted in the same cycle; when empty, a read is rejected even if a write is accepted in the same cycle.
REQ-021 On simultaneous accepted read and write, o_count is unchanged and both pointers advance.
REQ-022 Pointers wrap from depth-1 to 0; full/empty are derived from o_count (depth / 0).
REQ-023 o_count changes by +1 (write only), -1 (read only) or 0, one cycle after the accepting edge, and never exceeds depth.
REQ-024 o_afull = (o_count >= af_level); o_aempty = (o_count <= ae_level); both are combinational from o_count.
REQ-025 With fwft=0, out is a register loaded with the head entry on the edge that accepts a read, and holds at all other times.
REQ-026 With fwft=1, out combinationally shows the head entry when not empty and all-zero when empty; an accepted read exposes the next entry on the following cycle.
REQ-027 A rejected write sets o_ovf; a rejected read sets o_udf; both stay set until clr_err=1 or reset.
REQ-028 clr_err=1 with a same-cycle error event leaves the flag set (set wins).
REQ-029 Rejected operations change no pointer, count or memory content.

Reset
REQ-030 While reset=0, pointers, o_count, o_ovf, o_udf and the fwft=0 out register are 0, so o_empty=1, o_full=0, o_ready=1 and o_aempty=1.
REQ-031 Reset asserted mid-operation discards all contents immediately; memory array contents are not reset.

Structure
REQ-032 Default parameter values and the count-width function live in shared package fifo_pkg.
REQ-033 Storage is the sub-module fifo_mem (depth x width*bw): synchronous write port plus an asynchronous read port addressed by rd_ptr.

Verification
REQ-034 Test configuration: bw=8, width=2, depth=16.
REQ-035 Write 16 words 0x0100..0x010F -> o_full=1 and o_count=16 after the 16th write; a 17th write sets o_ovf and o_count stays 16.
REQ-036 (fwft=0) Read 16 words -> out equals 0x0100..0x010F in order, each valid the cycle after rd; then o_empty=1, and a further rd sets o_udf.
REQ-037 With the FIFO at 8 entries, hold wr=rd=1 for 40 cycles -> o_count stays 8, data order is preserved across the pointer wrap, and no error flag is set.
REQ-038 Sweep o_count 0..16 -> o_aempty=1 exactly for counts 0..2 and o_afull=1 exactly for counts 14..16.
REQ-039 (fwft=1) Write 0xABCD into the empty FIFO -> out=0xABCD on the next cycle with rd=0; after rd, out=0 and o_empty=1.
REQ-040 Drive reset=0 asynchronously with 5 entries stored -> o_count=0 and o_empty=1 before the next clock edge; after release, a pulse of clr_err with errors previously set reads o_ovf=o_udf=0.
